branch_outcome_gen: RTL and testbench
=====================================

// Module: branch_outcome_gen
// PURPOSE
//  Stimulus and scoring source for the 2-bit branch predictor (predictor_top).
//  - Drives branch_outcome into the predictor from a selectable pattern.
//  - Samples the predictor's prediction each outcome cycle and counts hits and misses.
//  - Sits beside predictor_top in self-checking runs; replaces hand-written outcome sequences.
// PARAMETERS
//  CNT_W     16        width of num_branches, hit_count and miss_count
//  LOOP_LEN  4         period of loop pattern (>=2): LOOP_LEN-1 taken, then 1 not-taken
//  SEED      16'hACE1  LFSR seed, reloaded on every accepted start; 0 is replaced by 16'h0001
// PORTS
//  clk             in   1      rising-edge clock
//  reset           in   1      synchronous, active-high reset
//  start           in   1      pulse; begins a run, accepted only in IDLE or DONE
//  mode            in   2      0=always taken, 1=alternate (T,N,...), 2=loop, 3=LFSR
//  num_branches    in   CNT_W  number of outcomes in the run; latched on start
//  prediction      in   1      from predictor: prediction for the current branch
//  branch_outcome  out  1      to predictor: actual outcome (1 = taken)
//  valid           out  1      branch_outcome is a live branch this cycle
//  busy            out  1      high in RUN
//  done            out  1      high in DONE; held until next start or reset
//  hit_count       out  CNT_W  outcomes where prediction == branch_outcome
//  miss_count      out  CNT_W  outcomes where prediction != branch_outcome
// BEHAVIOUR
//  - Reset (any state, including mid-run):
//    - state=IDLE; branch_outcome=0, valid=0, busy=0, done=0.
//    - hit_count=0, miss_count=0, remaining=0, loop index=0, lfsr=SEED.
//  - FSM: IDLE -> RUN -> DONE -> (start) RUN.
//  - start in IDLE/DONE at edge t:
//    - Latch mode and num_branches; clear both counts; reload LFSR.
//    - Reset loop index; clear alternate phase.
//    - If num_branches==0: go to DONE at t+1 (done=1, counts 0, valid never rises).
//    - Else: enter RUN; first outcome driven with valid=1 from t+1.
//  - start while in RUN is ignored. mode and num_branches changes are ignored outside start.
//  - RUN: one outcome per cycle, registered. At each edge with valid=1:
//    - Compare prediction with branch_outcome as presented in that cycle.
//    - Increment hit_count or miss_count, exactly one of the two.
//    - Advance the pattern; decrement remaining.
//  - Last outcome (remaining==1): after its compare edge, state=DONE, valid=0, busy=0, done=1.
//  - Patterns (outcome k = 0,1,2,...):
//    - mode 0: always 1.
//    - mode 1: 1 for even k, 0 for odd k.
//    - mode 2: 0 when (k mod LOOP_LEN)==LOOP_LEN-1, else 1. Index wraps to 0.
//    - mode 3: lfsr[0]. Fibonacci x^16+x^14+x^13+x^11+1, shift right, step once per outcome.
//  - Counts: hit_count+miss_count == number of outcomes issued; no overflow (sum <= num_branches).
//  - branch_outcome holds its last value when valid=0 (it is 0 after reset).
//  - Counts are stable and readable in DONE.
// TESTING (bench ties prediction to 1 unless stated)
//  - mode0, N=20: 20 valid cycles of outcome 1 -> hit=20, miss=0; done 1 cycle after last valid.
//  - mode1, N=10: outcomes 1,0,1,0,... -> hit=5, miss=5.
//  - mode2, LOOP_LEN=4, N=8: outcomes 1,1,1,0,1,1,1,0 -> hit=6, miss=2.
//  - N=0 start: done=1 the next cycle; valid stays 0; counts 0.
//  - Reset and restart:
//    - reset asserted after 3 outcomes of N=10 -> next cycle IDLE, counts 0, valid=0.
//    - start in DONE clears counts and reruns.
//  - mode3 with predictor_top connected:
//    - hit+miss == N=100.
//    - Outcome stream matches software LFSR (SEED=16'hACE1).
//    - start pulse during RUN ignored.

Source files
------------

// File: rtl/branch_outcome_gen_if.sv
// Bundle between the branch outcome generator and whoever controls/observes it:
// run control, the predictor's prediction and the generated outcome stream with scores.
interface branch_outcome_gen_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] num_branches;
    logic             prediction;
    logic             branch_outcome;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    // Controller / predictor side: launches runs, supplies predictions, reads scores.
    modport master (
        output start, mode, num_branches, prediction,
        input  branch_outcome, valid, busy, done, hit_count, miss_count
    );

    // Generator side.
    modport slave (
        input  start, mode, num_branches, prediction,
        output branch_outcome, valid, busy, done, hit_count, miss_count
    );
endinterface

// File: rtl/branch_outcome_gen.sv
// Branch outcome generator: drives a patterned taken/not-taken stream into a
// branch predictor, one outcome per cycle, and scores the predictor's guesses.
module branch_outcome_gen #(
    parameter int          CNT_W    = 16,
    parameter int          LOOP_LEN = 4,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_outcome_gen_if.slave  bus
);
    localparam int IDX_W = (LOOP_LEN > 2) ? $clog2(LOOP_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LOOP_LEN - 1);
    // An all-zero LFSR would lock up, so a zero seed is swapped for 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [CNT_W-1:0] hit_reg, miss_reg;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             phase_reg, phase_next;
    logic [15:0]      lfsr_reg, lfsr_next;
    logic             outcome_reg, outcome_next;
    logic [1:0]       mode_sel;
    logic             start_ok, fire, last, load_outcome;
    logic             valid_int, busy_int, done_int;

    assign start_ok = bus.start && (state_reg != RUN);
    assign fire     = (state_reg == RUN);
    assign last     = (remaining_reg == CNT_W'(1));
    // The held outcome only changes when a new live outcome follows; after the
    // final compare it keeps the last value driven.
    assign load_outcome = (start_ok && (bus.num_branches != '0)) || (fire && !last);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: start is honoured only outside RUN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start_ok) state_next = (bus.num_branches == '0) ? DONE : RUN;
            RUN:        if (last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        valid_int = (state_reg == RUN);
        busy_int  = (state_reg == RUN);
        done_int  = (state_reg == DONE);
    end

    // Pattern generator: next pattern state, and the outcome it produces.
    always_comb begin
        idx_next   = idx_reg;
        phase_next = phase_reg;
        lfsr_next  = lfsr_reg;
        mode_sel   = mode_reg;
        if (start_ok) begin
            idx_next   = '0;
            phase_next = 1'b0;
            lfsr_next  = SEED_EFF;
            mode_sel   = bus.mode;
        end else if (fire) begin
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            phase_next = ~phase_reg;
            lfsr_next  = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
        end
        case (mode_sel)
            2'd0:    outcome_next = 1'b1;
            2'd1:    outcome_next = ~phase_next;
            2'd2:    outcome_next = (idx_next != IDX_LAST);
            default: outcome_next = lfsr_next[0];
        endcase
    end

    // Run bookkeeping, scoring and the registered outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg      <= 2'd0;
            remaining_reg <= '0;
            hit_reg       <= '0;
            miss_reg      <= '0;
            idx_reg       <= '0;
            phase_reg     <= 1'b0;
            lfsr_reg      <= SEED_EFF;
            outcome_reg   <= 1'b0;
        end else begin
            if (start_ok) begin
                mode_reg      <= bus.mode;
                remaining_reg <= bus.num_branches;
                hit_reg       <= '0;
                miss_reg      <= '0;
            end else if (fire) begin
                remaining_reg <= remaining_reg - 1'b1;
                if (bus.prediction == outcome_reg) hit_reg  <= hit_reg + 1'b1;
                else                               miss_reg <= miss_reg + 1'b1;
            end
            idx_reg   <= idx_next;
            phase_reg <= phase_next;
            lfsr_reg  <= lfsr_next;
            if (load_outcome) outcome_reg <= outcome_next;
        end
    end

    assign bus.branch_outcome = outcome_reg;
    assign bus.valid          = valid_int;
    assign bus.busy           = busy_int;
    assign bus.done           = done_int;
    assign bus.hit_count      = hit_reg;
    assign bus.miss_count     = miss_reg;
endmodule

// File: tb/tb_branch_outcome_gen.sv
// Bench for branch_outcome_gen: random and directed runs scored against a
// reference model of the outcome patterns and the hit/miss tally.
module tb_branch_outcome_gen;
    localparam int          CNT_W    = 16;
    localparam int          LOOP_LEN = 4;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_outcome_gen_if #(.CNT_W(CNT_W)) bus ();

    branch_outcome_gen #(.CNT_W(CNT_W), .LOOP_LEN(LOOP_LEN), .SEED(SEED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Software LFSR: x^16+x^14+x^13+x^11+1, right shift, feedback into bit 15.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Outcome k of a run in the given mode (lf is the LFSR after k steps).
    function automatic logic model_outcome(input int mode, input int k, input logic [15:0] lf);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2) == 0;
            2:       return (k % LOOP_LEN) != (LOOP_LEN - 1);
            default: return lf[0];
        endcase
    endfunction

    // One run: start, check every outcome, then the final DONE scores.
    // abort_at>0 asserts reset before outcome abort_at; poke pulses start mid-run.
    task automatic run(input int mode, input int n, input bit rand_pred,
                       input int abort_at, input bit poke);
        logic [15:0] lf = SEED;
        int hits = 0, misses = 0;
        logic exp_o, last_o, pred;
        last_o = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'(mode); bus.num_branches = CNT_W'(n);
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = 2'($urandom);
        bus.num_branches = CNT_W'($urandom);
        if (n == 0) begin
            check_val("n0_done",  32'(bus.done),  32'd1);
            check_val("n0_valid", 32'(bus.valid), 32'd0);
            check_val("n0_hit",   32'(bus.hit_count),  32'd0);
            check_val("n0_miss",  32'(bus.miss_count), 32'd0);
            @(negedge clk);
            check_val("n0_valid2", 32'(bus.valid), 32'd0);
            check_val("n0_done2",  32'(bus.done),  32'd1);
            $display("run mode=%0d n=0 -> done, counts 0", mode);
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (abort_at > 0 && k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_val("rst_valid", 32'(bus.valid), 32'd0);
                check_val("rst_busy",  32'(bus.busy),  32'd0);
                check_val("rst_done",  32'(bus.done),  32'd0);
                check_val("rst_hit",   32'(bus.hit_count),  32'd0);
                check_val("rst_miss",  32'(bus.miss_count), 32'd0);
                check_val("rst_out",   32'(bus.branch_outcome), 32'd0);
                $display("run mode=%0d n=%0d reset after %0d outcomes", mode, n, k);
                return;
            end
            exp_o = model_outcome(mode, k, lf);
            check_val("valid", 32'(bus.valid), 32'd1);
            check_val("busy",  32'(bus.busy),  32'd1);
            check_val("done_in_run", 32'(bus.done), 32'd0);
            check_val($sformatf("outcome[%0d]", k), 32'(bus.branch_outcome), 32'(exp_o));
            if (k == 0) begin
                check_val("clr_hit",  32'(bus.hit_count),  32'd0);
                check_val("clr_miss", 32'(bus.miss_count), 32'd0);
            end
            pred = rand_pred ? 1'($urandom) : 1'b1;
            bus.prediction = pred;
            if (pred == exp_o) hits++;
            else               misses++;
            bus.start = (poke && k == 2);
            if (poke && k == 2) bus.num_branches = '0;
            last_o = exp_o;
            lf = lfsr_step(lf);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.prediction = 1'b1;
        check_val("end_valid", 32'(bus.valid), 32'd0);
        check_val("end_busy",  32'(bus.busy),  32'd0);
        check_val("end_done",  32'(bus.done),  32'd1);
        check_val("end_hit",   32'(bus.hit_count),  32'(hits));
        check_val("end_miss",  32'(bus.miss_count), 32'(misses));
        check_val("end_hold",  32'(bus.branch_outcome), 32'(last_o));
        @(negedge clk);
        check_val("stable_hit", 32'(bus.hit_count), 32'(hits));
        $display("run mode=%0d n=%0d hits=%0d misses=%0d", mode, n, hits, misses);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.mode = 2'd0; bus.num_branches = '0; bus.prediction = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_valid", 32'(bus.valid), 32'd0);
        check_val("reset_busy",  32'(bus.busy),  32'd0);
        check_val("reset_done",  32'(bus.done),  32'd0);
        check_val("reset_out",   32'(bus.branch_outcome), 32'd0);
        check_val("reset_hit",   32'(bus.hit_count),  32'd0);
        check_val("reset_miss",  32'(bus.miss_count), 32'd0);
        reset = 1'b0;

        run(0, 20, 1'b0, 0, 1'b0);
        check_val("m0_hit_const", 32'(bus.hit_count), 32'd20);
        run(1, 10, 1'b0, 0, 1'b0);
        check_val("m1_miss_const", 32'(bus.miss_count), 32'd5);
        run(2, 8, 1'b0, 0, 1'b0);
        check_val("m2_miss_const", 32'(bus.miss_count), 32'd2);
        run(0, 0, 1'b0, 0, 1'b0);
        run(1, 10, 1'b0, 3, 1'b0);
        run(2, 8, 1'b1, 0, 1'b0);
        run(3, 100, 1'b1, 0, 1'b1);
        check_val("m3_sum", 32'(bus.hit_count) + 32'(bus.miss_count), 32'd100);
        for (int r = 0; r < 8; r++)
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 1'b1, 0, r[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
